mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, giving the number of requester channels (0 = fetch, 1 = load, 2 = store).
REQ-002 The block SHALL have parameter XLEN, default 32, giving the data width.
REQ-003 The block SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-004 The block SHALL have parameter MAX_OUT, default 4 (power of two, at least 2), giving the maximum number of outstanding memory transactions.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port ch_req_valid, input, NUM_CH bits: per-channel request valid.
REQ-008 The block SHALL have port ch_req_ready, output, NUM_CH bits: per-channel request accepted.
REQ-009 The block SHALL have port ch_req_write, input, NUM_CH bits: per-channel write (1) or read (0).
REQ-010 The block SHALL have port ch_req_addr, input, NUM_CH*ADDR_W bits: per-channel address, channel i at slice [i*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port ch_req_data, input, NUM_CH*XLEN bits: per-channel write data.
REQ-012 The block SHALL have port ch_resp_valid, output, NUM_CH bits: one-hot response strobe.
REQ-013 The block SHALL have port ch_resp_data, output, XLEN bits: response data, shared by all channels.
REQ-014 The block SHALL have port ch_resp_exc, output, 5 bits: response exception {valid, code[3:0]}, shared by all channels.
REQ-015 The block SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_req_write (output, 1), mem_req_addr (output, ADDR_W) and mem_req_data (output, XLEN): the downstream request.
REQ-016 The block SHALL have ports mem_resp_valid (input, 1), mem_resp_data (input, XLEN) and mem_resp_exc (input, 5): the downstream response, returned in order.
REQ-017 The block SHALL have port outstanding, output, clog2(MAX_OUT)+1 bits: in-flight transaction count.
REQ-018 The block SHALL have port err_unexpected, output, 1 bit: sticky flag for a response received with none outstanding.

Function
REQ-019 Arbitration SHALL be round-robin: priority search starts at rr_ptr and wraps modulo NUM_CH; grant is combinational from ch_req_valid.
REQ-020 mem_req_valid SHALL be 1 iff some channel is valid and outstanding < MAX_OUT; mem_req_* SHALL carry the granted channel's fields.
REQ-021 ch_req_ready[i] SHALL equal grant[i] & mem_req_ready & (outstanding < MAX_OUT); at most one bit SHALL be set per cycle.
REQ-022 On a handshake (mem_req_valid & mem_req_ready), rr_ptr SHALL become (granted+1) mod NUM_CH, and {channel id, write} SHALL be pushed into a MAX_OUT-deep tag FIFO.
REQ-023 On mem_resp_valid with the FIFO non-empty, the block SHALL pop the head and, in the same cycle, drive ch_resp_valid[head.id]=1, ch_resp_data=mem_resp_data and ch_resp_exc=mem_resp_exc, giving zero added response latency.
REQ-024 Writes SHALL receive a response strobe like reads; ch_resp_data for a write response SHALL be 0.
REQ-025 A simultaneous push and pop SHALL leave the outstanding count unchanged; a full FIFO SHALL block the push even when a pop occurs in the same cycle.
REQ-026 The FIFO read and write pointers SHALL wrap modulo MAX_OUT; full/empty SHALL be derived from outstanding, never from pointer equality alone.
REQ-027 mem_resp_valid while the FIFO is empty SHALL be dropped (no ch_resp_valid) and SHALL set err_unexpected, which stays 1 until reset.
REQ-028 Request outputs are valid/ready: while ch_req_ready is low, the block SHALL not require the channel to hold its request, and SHALL not latch it.

Reset
REQ-029 On RESET low, the block SHALL asynchronously clear rr_ptr, both FIFO pointers, outstanding and err_unexpected to 0.
REQ-030 During reset, ch_req_ready, ch_resp_valid and mem_req_valid SHALL be 0, and ch_resp_data and ch_resp_exc SHALL be 0.
REQ-031 Reset mid-operation SHALL discard all outstanding tags; any later mem_resp_valid without a matching tag SHALL fall under REQ-027.

Structure
REQ-032 A shared package mem_arb_pkg SHALL hold the exception struct {valid, code[3:0]}, the tag struct {id, write}, and the channel constants CH_FETCH=0, CH_LOAD=1, CH_STORE=2.
REQ-033 The tag FIFO SHALL be the sub-module tag_fifo, parametrised by width and depth, with asynchronous active-low reset.

Verification
REQ-034 Bench SHALL cover: all three channels valid, mem_req_ready=1, 6 cycles -> grants in order 0,1,2,0,1,2.
REQ-035 Bench SHALL cover: MAX_OUT=4 and 5 load requests with no responses -> 4 handshakes, then ready=0 and outstanding=4.
REQ-036 Bench SHALL cover: FIFO full with a simultaneous response and new request -> response routed, request not accepted, outstanding 4 to 3.
REQ-037 Bench SHALL cover: fetch to 0x100, then load to 0x200, responses 0xAAAA and 0xBBBB -> ch_resp_valid=001 with 0xAAAA, then 010 with 0xBBBB.
REQ-038 Bench SHALL cover: mem_resp_valid with outstanding=0 -> no ch_resp_valid and err_unexpected=1 until reset.
REQ-039 Bench SHALL cover: RESET low with 2 outstanding -> outstanding=0 and rr_ptr=0 immediately; after release, a store request is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter: channel ids,
// response exception record and the in-flight tag carried through the tag FIFO.
package mem_arb_pkg;

  localparam int CH_ID_W = 4;
  localparam int EXC_W   = 5;

  localparam logic [CH_ID_W-1:0] CH_FETCH = 4'd0;
  localparam logic [CH_ID_W-1:0] CH_LOAD  = 4'd1;
  localparam logic [CH_ID_W-1:0] CH_STORE = 4'd2;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } exc_t;

  typedef struct packed {
    logic [CH_ID_W-1:0] id;
    logic               write;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Round-robin successor of a channel id, wrapping at num_ch.
  function automatic logic [CH_ID_W-1:0] next_ch(input logic [CH_ID_W-1:0] cur,
                                                 input int num_ch);
    if (int'(cur) >= num_ch - 1) return '0;
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// In-order tag FIFO recording {channel, write} of every issued request.
// Occupancy is the authoritative full/empty source; pointers simply wrap.
module tag_fifo #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging fetch/load/store requests onto one memory port
// and routing in-order memory responses back to the issuing channel.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_CH  = 3,
  parameter  int XLEN    = 32,
  parameter  int ADDR_W  = 32,
  parameter  int MAX_OUT = 4,
  localparam int OUT_W   = $clog2(MAX_OUT) + 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH-1:0]        ch_req_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH*XLEN-1:0]   ch_req_data,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  output logic [XLEN-1:0]          ch_resp_data,
  output logic [EXC_W-1:0]         ch_resp_exc,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_write,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [XLEN-1:0]          mem_req_data,
  input  logic                     mem_resp_valid,
  input  logic [XLEN-1:0]          mem_resp_data,
  input  logic [EXC_W-1:0]         mem_resp_exc,
  output logic [OUT_W-1:0]         outstanding,
  output logic                     err_unexpected
);

  // Handshake rule on both sides: a transfer happens in a cycle where valid
  // and ready are both high; nothing is latched or held otherwise.

  logic [CH_ID_W-1:0] r_rr_ptr;
  logic               r_err_unexpected;

  logic [NUM_CH-1:0]  w_grant;
  logic [CH_ID_W-1:0] w_grant_idx;
  logic               w_any_valid;
  logic               w_full;
  logic               w_empty;
  logic               w_hs;
  logic               w_pop;
  logic               w_route;
  tag_t               w_push_tag;
  logic [TAG_W-1:0]   w_head_bits;
  tag_t               w_head;
  exc_t               w_resp_exc;

  always_comb begin : p_grant
    int j;
    j           = 0;
    w_grant     = '0;
    w_grant_idx = '0;
    w_any_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      for (int i = 0; i < NUM_CH; i++) begin
        if (i == j && !w_any_valid && ch_req_valid[i]) begin
          w_any_valid = 1'b1;
          w_grant[i]  = 1'b1;
          w_grant_idx = CH_ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        mem_req_write = ch_req_write[i];
        mem_req_addr  = ch_req_addr[i*ADDR_W +: ADDR_W];
        mem_req_data  = ch_req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign mem_req_valid = RESET & w_any_valid & ~w_full;
  assign w_hs          = mem_req_valid & mem_req_ready;
  assign ch_req_ready  = w_hs ? w_grant : '0;

  assign w_push_tag = '{id: w_grant_idx, write: mem_req_write};
  assign w_pop      = mem_resp_valid & ~w_empty;
  assign w_route    = w_pop & RESET;
  assign w_head     = tag_t'(w_head_bits);
  assign w_resp_exc = exc_t'(mem_resp_exc);

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_push  (w_hs),
    .i_wdata (w_push_tag),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_count (outstanding),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Response goes straight through in the cycle it arrives; writes carry no data.
  always_comb begin
    ch_resp_valid = '0;
    ch_resp_data  = '0;
    ch_resp_exc   = '0;
    if (w_route) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_head.id == CH_ID_W'(i)) ch_resp_valid[i] = 1'b1;
      end
      ch_resp_data = w_head.write ? '0 : mem_resp_data;
      ch_resp_exc  = w_resp_exc;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rr_ptr         <= '0;
      r_err_unexpected <= 1'b0;
    end else begin
      if (w_hs) r_rr_ptr <= next_ch(w_grant_idx, NUM_CH);
      if (mem_resp_valid && w_empty) r_err_unexpected <= 1'b1;
    end
  end

  assign err_unexpected = r_err_unexpected;

  a_ready_onehot: assert property (@(posedge CLK) disable iff (!RESET)
    $onehot0(ch_req_ready));
  a_out_bound: assert property (@(posedge CLK) disable iff (!RESET)
    outstanding <= OUT_W'(MAX_OUT));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: arbitration vector table plus
// hand-written sequences, with a response scoreboard keyed by issue order.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NUM_CH  = 3;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int MAX_OUT = 4;
  localparam int OUT_W   = 3;
  localparam int RW      = NUM_CH + XLEN + 5;

  logic                     CLK = 1'b0;
  logic                     RESET = 1'b0;
  logic [NUM_CH-1:0]        ch_req_valid;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH-1:0]        ch_req_write;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
  logic [NUM_CH*XLEN-1:0]   ch_req_data;
  logic [NUM_CH-1:0]        ch_resp_valid;
  logic [XLEN-1:0]          ch_resp_data;
  logic [4:0]               ch_resp_exc;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_write;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic [XLEN-1:0]          mem_req_data;
  logic                     mem_resp_valid;
  logic [XLEN-1:0]          mem_resp_data;
  logic [4:0]               mem_resp_exc;
  logic [OUT_W-1:0]         outstanding;
  logic                     err_unexpected;

  mem_arbiter #(
    .NUM_CH(NUM_CH), .XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_write(ch_req_write), .ch_req_addr(ch_req_addr),
    .ch_req_data(ch_req_data), .ch_resp_valid(ch_resp_valid),
    .ch_resp_data(ch_resp_data), .ch_resp_exc(ch_resp_exc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .mem_resp_exc(mem_resp_exc),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];
  logic [3:0]    tag_q[$];

  typedef struct {
    logic [2:0] v;
    logic       rdy;
    logic       resp;
    logic [2:0] exp_ready;
    logic       exp_mv;
    int         exp_ch;
    logic [2:0] exp_out;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_ch(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d);
    ch_req_write[ch]                  = w;
    ch_req_addr[ch*ADDR_W +: ADDR_W] = a;
    ch_req_data[ch*XLEN +: XLEN]     = d;
  endtask

  task automatic default_channels();
    set_ch(0, 1'b0, 32'h0000_1000, 32'hD000_0000);
    set_ch(1, 1'b0, 32'h0000_2000, 32'hD000_0001);
    set_ch(2, 1'b1, 32'h0000_3000, 32'hD000_0002);
  endtask

  task automatic idle();
    ch_req_valid   = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_exc   = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    idle();
    default_channels();
    tag_q.delete();
    exp_q.delete();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Drives a memory response and records what the channel side must show.
  task automatic issue_resp(input logic [31:0] d, input logic [4:0] e);
    logic [3:0] t;
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    mem_resp_exc   = e;
    if (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      exp_q.push_back({t[2:0], (t[3] ? 32'h0 : d), e});
    end
  endtask

  task automatic check_resp(input string name);
    logic [RW-1:0] r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check(name, {ch_resp_valid, ch_resp_data, ch_resp_exc}, r);
    end else begin
      check({name, "_none"}, ch_resp_valid, 0);
    end
  endtask

  function automatic logic [31:0] ch_addr(input int ch);
    return 32'h0000_1000 * (ch + 1);
  endfunction

  initial begin
    vecs[0]  = '{3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 0, 3'd0};
    vecs[1]  = '{3'b111, 1'b0, 1'b0, 3'b000, 1'b1, 0, 3'd0};
    vecs[2]  = '{3'b111, 1'b1, 1'b0, 3'b001, 1'b1, 0, 3'd1};
    vecs[3]  = '{3'b111, 1'b1, 1'b0, 3'b010, 1'b1, 1, 3'd2};
    vecs[4]  = '{3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 2, 3'd2};
    vecs[5]  = '{3'b110, 1'b1, 1'b0, 3'b010, 1'b1, 1, 3'd3};
    vecs[6]  = '{3'b011, 1'b1, 1'b0, 3'b001, 1'b1, 0, 3'd4};
    vecs[7]  = '{3'b111, 1'b1, 1'b0, 3'b000, 1'b0, 0, 3'd4};
    vecs[8]  = '{3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 0, 3'd3};
    vecs[9]  = '{3'b100, 1'b1, 1'b1, 3'b100, 1'b1, 2, 3'd3};
    vecs[10] = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 0, 3'd2};
    vecs[11] = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 0, 3'd1};
    vecs[12] = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 0, 3'd0};

    // Reset state, with active inputs that must be masked.
    default_channels();
    RESET          = 1'b0;
    ch_req_valid   = 3'b111;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h1234_5678;
    mem_resp_exc   = 5'h1F;
    @(negedge CLK); #1;
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_unexpected, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_ready", ch_req_ready, 0);
    check("rst_resp", {ch_resp_valid, ch_resp_data, ch_resp_exc}, 0);
    idle();
    @(negedge CLK);
    RESET = 1'b1;

    // Arbitration vector table.
    for (int n = 0; n < 13; n++) begin
      @(negedge CLK);
      ch_req_valid  = vecs[n].v;
      mem_req_ready = vecs[n].rdy;
      if (vecs[n].resp) issue_resp($urandom, 5'($urandom_range(0, 31)));
      else mem_resp_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_ready", n), ch_req_ready, vecs[n].exp_ready);
      check($sformatf("vec%0d_mem_valid", n), mem_req_valid, vecs[n].exp_mv);
      if (vecs[n].exp_mv) begin
        check($sformatf("vec%0d_addr", n), mem_req_addr, ch_addr(vecs[n].exp_ch));
        check($sformatf("vec%0d_data", n), mem_req_data, 32'hD000_0000 + vecs[n].exp_ch);
        check($sformatf("vec%0d_write", n), mem_req_write, vecs[n].exp_ch == 2);
      end
      check_resp($sformatf("vec%0d_resp", n));
      if (vecs[n].exp_ready != 0) tag_q.push_back({vecs[n].exp_ready[2], vecs[n].exp_ready});
      @(posedge CLK); #1;
      check($sformatf("vec%0d_out", n), outstanding, vecs[n].exp_out);
    end

    // Rotation with all three channels requesting.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      ch_req_valid  = 3'b111;
      mem_req_ready = 1'b1;
      if (c > 0) issue_resp($urandom, 5'($urandom_range(0, 31)));
      else mem_resp_valid = 1'b0;
      #1;
      check($sformatf("rr%0d_grant", c), ch_req_ready, 3'b001 << (c % 3));
      check_resp($sformatf("rr%0d_resp", c));
      tag_q.push_back({(c % 3) == 2, 3'b001 << (c % 3)});
      @(posedge CLK);
    end
    @(negedge CLK);
    ch_req_valid = '0;
    issue_resp($urandom, 5'h00);
    #1 check_resp("rr_drain_resp");
    @(posedge CLK); #1;
    check("rr_drain_out", outstanding, 0);

    // Fill to MAX_OUT with loads, then a response alongside a blocked request.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      ch_req_valid  = 3'b010;
      mem_req_ready = 1'b1;
      #1;
      check($sformatf("fill%0d_ready", c), ch_req_ready, (c < 4) ? 3'b010 : 3'b000);
      if (c < 4) tag_q.push_back(4'b0010);
      @(posedge CLK);
    end
    #1 check("fill_out", outstanding, 4);
    @(negedge CLK);
    issue_resp(32'hCAFE_0001, 5'h12);
    #1;
    check("full_pop_ready", ch_req_ready, 0);
    check("full_pop_mem_valid", mem_req_valid, 0);
    check_resp("full_pop_resp");
    @(posedge CLK); #1;
    check("full_pop_out", outstanding, 3);
    @(negedge CLK);
    ch_req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      issue_resp($urandom, 5'h00);
      #1 check_resp($sformatf("fill_drain%0d", c));
      @(negedge CLK);
    end
    mem_resp_valid = 1'b0;
    #1 check("fill_drain_out", outstanding, 0);

    // Fetch then load, responses routed in order.
    do_reset();
    set_ch(0, 1'b0, 32'h100, 32'h0);
    set_ch(1, 1'b0, 32'h200, 32'h0);
    @(negedge CLK);
    ch_req_valid  = 3'b001;
    mem_req_ready = 1'b1;
    #1;
    check("fl_fetch_addr", mem_req_addr, 32'h100);
    check("fl_fetch_ready", ch_req_ready, 3'b001);
    tag_q.push_back(4'b0001);
    @(negedge CLK);
    ch_req_valid = 3'b010;
    #1;
    check("fl_load_addr", mem_req_addr, 32'h200);
    check("fl_load_ready", ch_req_ready, 3'b010);
    tag_q.push_back(4'b0010);
    @(negedge CLK);
    ch_req_valid = '0;
    issue_resp(32'hAAAA, 5'h00);
    #1;
    check("fl_resp0_valid", ch_resp_valid, 3'b001);
    check_resp("fl_resp0");
    @(negedge CLK);
    issue_resp(32'hBBBB, 5'h00);
    #1;
    check("fl_resp1_data", ch_resp_data, 32'hBBBB);
    check_resp("fl_resp1");
    @(negedge CLK);
    mem_resp_valid = 1'b0;

    // Unexpected response with nothing outstanding.
    do_reset();
    @(negedge CLK);
    issue_resp(32'hDEAD_BEEF, 5'h11);
    #1;
    check_resp("unexp_resp");
    check("unexp_err_before", err_unexpected, 0);
    @(negedge CLK);
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) @(negedge CLK);
    #1 check("unexp_err_sticky", err_unexpected, 1);

    // Reset in the middle of two outstanding transactions.
    @(negedge CLK);
    ch_req_valid  = 3'b011;
    mem_req_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    ch_req_valid  = 3'b101;
    mem_req_ready = 1'b0;
    #1;
    check("mid_pre_out", outstanding, 2);
    check("mid_pre_addr", mem_req_addr, ch_addr(2));
    #2;
    RESET          = 1'b0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    check("mid_rst_out", outstanding, 0);
    check("mid_rst_err", err_unexpected, 0);
    check("mid_rst_mem_valid", mem_req_valid, 0);
    check("mid_rst_ready", ch_req_ready, 0);
    check("mid_rst_resp", {ch_resp_valid, ch_resp_data, ch_resp_exc}, 0);
    tag_q.delete();
    @(negedge CLK);
    RESET          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    #1 check("mid_rr_addr", mem_req_addr, ch_addr(0));
    @(negedge CLK);
    ch_req_valid  = 3'b100;
    mem_req_ready = 1'b1;
    #1 check("mid_store_grant", ch_req_ready, 3'b100);
    tag_q.push_back({1'b1, 3'b100});
    @(negedge CLK);
    ch_req_valid = '0;
    issue_resp(32'h5555_AAAA, 5'h03);
    #1 check_resp("mid_store_resp");
    @(negedge CLK);
    issue_resp(32'h7777_0000, 5'h00);
    #1 check_resp("mid_stale_resp");
    @(negedge CLK);
    idle();
    #1 check("mid_stale_err", err_unexpected, 1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
